// File: rtl/twiddle_mult_pkg.sv
// Shared constants and index helpers for the twiddle rotation datapath.
// A complex word is packed {real, imag}, each component MULT_WIDTH bits,
// two's complement, twiddles in Q1.(MULT_WIDTH-1).
package twiddle_mult_pkg;

  // Default component width for the whole FFT datapath.
  localparam int MULT_WIDTH_DEF = 18;

  // Imaginary component always starts at bit 0 of a packed complex word.
  localparam int IM_LSB = 0;

  // Real component occupies the upper half of a packed complex word.
  function automatic int re_msb(input int w);
    return 2 * w - 1;
  endfunction

  function automatic int re_lsb(input int w);
    return w;
  endfunction

  function automatic int im_msb(input int w);
    return w - 1;
  endfunction

  // Number of fractional bits in a Q1.(w-1) twiddle component.
  function automatic int frac_bits(input int w);
    return w - 1;
  endfunction

endpackage

// File: rtl/fft_round_sat.sv
// Round-half-up and saturate one full-precision component sum back to
// W bits. Purely combinational; the caller registers the result.
module fft_round_sat
  import twiddle_mult_pkg::*;
#(
  parameter int W = MULT_WIDTH_DEF
) (
  input  logic signed [2*W:0] sum,
  output logic [W-1:0]        y,
  output logic                sat
);

  localparam int FRAC = frac_bits(W);

  // Half an output LSB, added before the truncating shift.
  localparam logic signed [2*W:0] RND = {{(2*W){1'b0}}, 1'b1} << (FRAC - 1);

  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [2*W:0] rounded;
  logic signed [2*W:0] shifted;
  logic                in_range;

  // Round, scale, and clamp to the nearest representable bound on overflow.
  // The value fits in W bits exactly when every bit from the W-bit sign
  // position upward is a copy of the same sign.
  always_comb begin
    rounded  = sum + RND;
    shifted  = rounded >>> FRAC;
    in_range = (&shifted[2*W:W-1]) || (~|shifted[2*W:W-1]);
    sat      = !in_range;
    y        = shifted[W-1:0];
    if (!in_range) begin
      y = shifted[2*W] ? NEG_MIN : POS_MAX;
    end
  end

endmodule

// File: rtl/twiddle_mult.sv
// Three-stage complex twiddle multiplier for an FFT butterfly.
// ob = ib * iw (rounded, saturated), oa = ia delayed to line up with ob.
// The whole pipeline advances together whenever the output register is
// empty or being accepted, so stalls back up to i_ready in one cycle.
module twiddle_mult
  import twiddle_mult_pkg::*;
#(
  parameter int MULT_WIDTH = MULT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [2*MULT_WIDTH-1:0] ia,
  input  logic [2*MULT_WIDTH-1:0] ib,
  input  logic [2*MULT_WIDTH-1:0] iw,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [2*MULT_WIDTH-1:0] oa,
  output logic [2*MULT_WIDTH-1:0] ob,
  output logic                    o_sat
);

  localparam int W      = MULT_WIDTH;
  localparam int CW     = 2 * W;
  localparam int RE_MSB = re_msb(W);
  localparam int RE_LSB = re_lsb(W);
  localparam int IM_MSB = im_msb(W);

  logic adv;

  // Stage 1: registered operands.
  logic          s1_valid_reg;
  logic [CW-1:0] s1_a_reg;
  logic [CW-1:0] s1_b_reg;
  logic [CW-1:0] s1_w_reg;

  // Stage 2: four partial products.
  logic                 s2_valid_reg;
  logic [CW-1:0]        s2_a_reg;
  logic signed [CW-1:0] s2_rr_reg;
  logic signed [CW-1:0] s2_ii_reg;
  logic signed [CW-1:0] s2_ri_reg;
  logic signed [CW-1:0] s2_ir_reg;

  // Stage 3: output register.
  logic          o_valid_reg;
  logic [CW-1:0] oa_reg;
  logic [CW-1:0] ob_reg;
  logic          o_sat_reg;

  // Component views of stage 1, sign-extended to product width.
  logic signed [W-1:0]  br, bi, wr, wi;
  logic signed [CW-1:0] br_x, bi_x, wr_x, wi_x;

  // Combined sums, index 0 = real, 1 = imag, one bit wider than a product.
  logic signed [CW:0] sum_arr [2];
  logic [W-1:0]       rs_y    [2];
  logic               rs_sat  [2];

  assign adv     = !o_valid_reg || o_ready;
  assign i_ready = adv;

  assign br = s1_b_reg[RE_MSB:RE_LSB];
  assign bi = s1_b_reg[IM_MSB:IM_LSB];
  assign wr = s1_w_reg[RE_MSB:RE_LSB];
  assign wi = s1_w_reg[IM_MSB:IM_LSB];

  assign br_x = $signed({{W{br[W-1]}}, br});
  assign bi_x = $signed({{W{bi[W-1]}}, bi});
  assign wr_x = $signed({{W{wr[W-1]}}, wr});
  assign wi_x = $signed({{W{wi[W-1]}}, wi});

  // A W x W signed product always fits in 2W bits (even -1.0 * -1.0);
  // the sum of two of them needs one extra bit.
  assign sum_arr[0] = $signed({s2_rr_reg[CW-1], s2_rr_reg}) - $signed({s2_ii_reg[CW-1], s2_ii_reg});
  assign sum_arr[1] = $signed({s2_ri_reg[CW-1], s2_ri_reg}) + $signed({s2_ir_reg[CW-1], s2_ir_reg});

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_round_sat
      fft_round_sat #(
        .W(W)
      ) u_round_sat (
        .sum(sum_arr[gi]),
        .y  (rs_y[gi]),
        .sat(rs_sat[gi])
      );
    end
  endgenerate

  // Stage 1: capture the offered word (or a bubble) when the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_w_reg     <= '0;
    end else if (adv) begin
      s1_valid_reg <= i_valid;
      s1_a_reg     <= ia;
      s1_b_reg     <= ib;
      s1_w_reg     <= iw;
    end
  end

  // Stage 2: register the four cross products and carry ia along.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_a_reg     <= '0;
      s2_rr_reg    <= '0;
      s2_ii_reg    <= '0;
      s2_ri_reg    <= '0;
      s2_ir_reg    <= '0;
    end else if (adv) begin
      s2_valid_reg <= s1_valid_reg;
      s2_a_reg     <= s1_a_reg;
      s2_rr_reg    <= br_x * wr_x;
      s2_ii_reg    <= bi_x * wi_x;
      s2_ri_reg    <= br_x * wi_x;
      s2_ir_reg    <= bi_x * wr_x;
    end
  end

  // Stage 3: register the rounded, saturated rotation; saturation is only
  // flagged for real words so bubbles never carry a stale o_sat.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_reg <= 1'b0;
      oa_reg      <= '0;
      ob_reg      <= '0;
      o_sat_reg   <= 1'b0;
    end else if (adv) begin
      o_valid_reg <= s2_valid_reg;
      oa_reg      <= s2_a_reg;
      ob_reg      <= {rs_y[0], rs_y[1]};
      o_sat_reg   <= s2_valid_reg && (rs_sat[0] || rs_sat[1]);
    end
  end

  assign o_valid = o_valid_reg;
  assign oa      = oa_reg;
  assign ob      = ob_reg;
  assign o_sat   = o_sat_reg;

endmodule

// File: tb/tb_twiddle_mult.sv
// Self-checking bench for twiddle_mult: directed corner vectors, stall
// handling, mid-stream reset and a long randomized scoreboard run.
module tb_twiddle_mult;

  localparam int W  = 18;
  localparam int CW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [CW-1:0] ia = '0;
  logic [CW-1:0] ib = '0;
  logic [CW-1:0] iw = '0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [CW-1:0] oa;
  logic [CW-1:0] ob;
  logic          o_sat;

  twiddle_mult #(.MULT_WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .ia     (ia),
    .ib     (ib),
    .iw     (iw),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .oa     (oa),
    .ob     (ob),
    .o_sat  (o_sat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Snapshot of the handshake as seen just before each rising edge.
  logic          did_acc, did_out, s_rdy, s_vld, s_s;
  logic [CW-1:0] s_a, s_b;

  typedef struct packed {
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    logic          s;
  } exp_t;

  function automatic logic [CW-1:0] cpx(input longint r, input longint i);
    logic [W-1:0] rr, ii;
    rr = r[W-1:0];
    ii = i[W-1:0];
    return {rr, ii};
  endfunction

  // Reference: exact integer complex product, round half up, clamp.
  function automatic exp_t model(input logic [CW-1:0] a, input logic [CW-1:0] b, input logic [CW-1:0] w);
    longint br, bi, wr, wi, lim_hi, lim_lo;
    longint res [2];
    exp_t   e;
    lim_hi = (longint'(1) << (W - 1)) - 1;
    lim_lo = -(longint'(1) << (W - 1));
    br = $signed(b[CW-1:W]);
    bi = $signed(b[W-1:0]);
    wr = $signed(w[CW-1:W]);
    wi = $signed(w[W-1:0]);
    res[0] = br * wr - bi * wi;
    res[1] = br * wi + bi * wr;
    e.a = a;
    e.s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      res[k] = (res[k] + (longint'(1) << (W - 2))) >>> (W - 1);
      if (res[k] > lim_hi) begin
        res[k] = lim_hi;
        e.s = 1'b1;
      end else if (res[k] < lim_lo) begin
        res[k] = lim_lo;
        e.s = 1'b1;
      end
    end
    e.b = cpx(res[0], res[1]);
    return e;
  endfunction

  // Random component biased toward the extremes.
  function automatic logic [W-1:0] rnd_comp();
    logic [31:0]  r;
    logic [W-1:0] v;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       v = {1'b1, {(W-1){1'b0}}};
      1:       v = {1'b0, {(W-1){1'b1}}};
      2:       v = '0;
      default: v = r[W-1:0];
    endcase
    return v;
  endfunction

  function automatic logic [CW-1:0] rnd_word();
    return {rnd_comp(), rnd_comp()};
  endfunction

  // Drive one cycle of inputs, record the handshake, advance past the edge.
  task automatic step(input logic v, input logic [CW-1:0] a, input logic [CW-1:0] b,
                      input logic [CW-1:0] w, input logic ordy);
    i_valid = v;
    ia      = a;
    ib      = b;
    iw      = w;
    o_ready = ordy;
    #1;
    did_acc = i_valid && i_ready;
    did_out = o_valid && o_ready;
    s_rdy   = i_ready;
    s_vld   = o_valid;
    s_a     = oa;
    s_b     = ob;
    s_s     = o_sat;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step(1'b1, rnd_word(), rnd_word(), rnd_word(), 1'b1);
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
      n_cmp++; if (oa !== '0) begin n_err++; $display("FAIL reset_oa: got %h want 0", oa); end
      n_cmp++; if (ob !== '0) begin n_err++; $display("FAIL reset_ob: got %h want 0", ob); end
      n_cmp++; if (o_sat !== 1'b0) begin n_err++; $display("FAIL reset_o_sat: got %b want 0", o_sat); end
      n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
    end
    o_ready = 1'b0;
    #1;
    n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL reset_i_ready_no_oready: got %b want 1", i_ready); end
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step(1'b0, '0, '0, '0, 1'b1);
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_empty: o_valid got %b want 0", o_valid); end
    end
    $display("test_reset done");
  endtask

  task automatic test_directed();
    logic [CW-1:0] vb [7];
    logic [CW-1:0] vw [7];
    logic [CW-1:0] vo [7];
    logic          vs [7];
    logic [CW-1:0] a;
    int            lat, cnt;
    logic [CW-1:0] got_a, got_b;
    logic          got_s;
    vb[0] = cpx(65536, 0);        vw[0] = cpx(65536, 0);        vo[0] = cpx(32768, 0);        vs[0] = 1'b0;
    vb[1] = cpx(1, 0);            vw[1] = cpx(65536, 0);        vo[1] = cpx(1, 0);            vs[1] = 1'b0;
    vb[2] = cpx(1, 0);            vw[2] = cpx(65535, 0);        vo[2] = cpx(0, 0);            vs[2] = 1'b0;
    vb[3] = cpx(-131072, -131072); vw[3] = cpx(-131072, 0);     vo[3] = cpx(131071, 131071);  vs[3] = 1'b1;
    vb[4] = cpx(-1, 0);           vw[4] = cpx(65536, 0);        vo[4] = cpx(0, 0);            vs[4] = 1'b0;
    vb[5] = cpx(100, -3);         vw[5] = cpx(-131072, 0);      vo[5] = cpx(-100, 3);         vs[5] = 1'b0;
    vb[6] = cpx(-131072, -131072); vw[6] = cpx(131071, -131072); vo[6] = cpx(-131072, 1);     vs[6] = 1'b1;
    for (int t = 0; t < 7; t++) begin
      a = (t == 0) ? cpx(5, -7) : rnd_word();
      step(1'b1, a, vb[t], vw[t], 1'b1);
      lat = 0;
      cnt = 0;
      got_a = '0; got_b = '0; got_s = 1'b0;
      for (int n = 1; n <= 8; n++) begin
        step(1'b0, '0, '0, '0, 1'b1);
        if (did_out) begin
          cnt++;
          if (lat == 0) begin lat = n; got_a = s_a; got_b = s_b; got_s = s_s; end
        end
      end
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL dir%0d_latency: got %0d want 3", t, lat); end
      n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL dir%0d_count: got %0d want 1", t, cnt); end
      n_cmp++; if (got_a !== a) begin n_err++; $display("FAIL dir%0d_oa: got %h want %h", t, got_a, a); end
      n_cmp++; if (got_b !== vo[t]) begin n_err++; $display("FAIL dir%0d_ob: got %h want %h", t, got_b, vo[t]); end
      n_cmp++; if (got_s !== vs[t]) begin n_err++; $display("FAIL dir%0d_o_sat: got %b want %b", t, got_s, vs[t]); end
      $display("directed %0d: ob=%h o_sat=%b latency=%0d", t, got_b, got_s, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] wa [8];
    logic [CW-1:0] wb [8];
    logic [CW-1:0] ww [8];
    int            k, d;
    logic          ordy;
    exp_t          e;
    logic [2*CW:0] snap;
    for (int j = 0; j < 8; j++) begin
      wa[j] = rnd_word(); wb[j] = rnd_word(); ww[j] = rnd_word();
    end
    k = 0;
    d = 0;
    snap = '0;
    for (int c = 0; c < 40; c++) begin
      ordy = !(c >= 4 && c <= 6);
      if (k < 8) step(1'b1, wa[k], wb[k], ww[k], ordy);
      else       step(1'b0, '0, '0, '0, ordy);
      if (did_out) begin
        n_cmp++;
        if (d >= 8) begin
          n_err++; $display("FAIL b2b_extra_word: got %h want none", s_b);
        end else begin
          e = model(wa[d], wb[d], ww[d]);
          if ({s_a, s_b, s_s} !== e) begin
            n_err++; $display("FAIL b2b_word%0d: got %h/%h/%b want %h/%h/%b", d, s_a, s_b, s_s, e.a, e.b, e.s);
          end
          $display("b2b word %0d delivered at cycle %0d", d, c);
        end
        d++;
      end
      if (did_acc) k++;
      if (c >= 4 && c <= 6) begin
        n_cmp++; if (s_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_stall_i_ready c%0d: got %b want 0", c, s_rdy); end
      end
      if (c == 4) snap = {s_a, s_b, s_s};
      if (c >= 5 && c <= 7) begin
        n_cmp++;
        if ({s_vld, s_a, s_b, s_s} !== {1'b1, snap}) begin
          n_err++; $display("FAIL b2b_hold c%0d: got %h want %h", c, {s_vld, s_a, s_b, s_s}, {1'b1, snap});
        end
      end
      if (c > 8 && d >= 8) break;
    end
    n_cmp++; if (k !== 8) begin n_err++; $display("FAIL b2b_accepted: got %0d want 8", k); end
    n_cmp++; if (d !== 8) begin n_err++; $display("FAIL b2b_delivered: got %0d want 8", d); end
  endtask

  task automatic test_reset_midstream();
    int            cnt, lat;
    logic [CW-1:0] a, b, w;
    exp_t          e;
    logic [2*CW:0] got;
    for (int n = 0; n < 3; n++) step(1'b1, rnd_word(), rnd_word(), rnd_word(), 1'b1);
    rst = 1'b1;
    step(1'b0, '0, '0, '0, 1'b0);
    rst = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_o_valid: got %b want 0", o_valid); end
    n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_i_ready: got %b want 1", i_ready); end
    n_cmp++; if (ob !== '0) begin n_err++; $display("FAIL mid_reset_ob: got %h want 0", ob); end
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      step(1'b0, '0, '0, '0, 1'b1);
      if (did_out) cnt++;
    end
    n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL mid_reset_stale: got %0d words want 0", cnt); end
    a = rnd_word(); b = rnd_word(); w = rnd_word();
    e = model(a, b, w);
    step(1'b1, a, b, w, 1'b1);
    lat = 0;
    got = '0;
    for (int n = 1; n <= 6; n++) begin
      step(1'b0, '0, '0, '0, 1'b1);
      if (did_out && lat == 0) begin lat = n; got = {s_a, s_b, s_s}; end
    end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL mid_reset_latency: got %0d want 3", lat); end
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL mid_reset_word: got %h want %h", got, e); end
    $display("reset midstream: stale=%0d new latency=%0d", cnt, lat);
  endtask

  task automatic test_random();
    exp_t          q [$];
    exp_t          e;
    int            nacc, cyc, nout;
    logic          v, ordy, prev_stall;
    logic [CW-1:0] a, b, w;
    logic [2*CW:0] prev;
    nacc = 0; cyc = 0; nout = 0;
    prev_stall = 1'b0;
    prev = '0;
    while ((nacc < 10000 || q.size() > 0) && cyc < 60000) begin
      v    = (nacc < 10000) && ($urandom_range(0, 99) < 70);
      ordy = (nacc >= 10000) || ($urandom_range(0, 99) < 75);
      a = rnd_word(); b = rnd_word(); w = rnd_word();
      step(v, a, b, w, ordy);
      cyc++;
      n_cmp++;
      if (s_rdy !== (!s_vld || ordy)) begin n_err++; $display("FAIL rnd_i_ready cyc%0d: got %b want %b", cyc, s_rdy, !s_vld || ordy); end
      if (prev_stall) begin
        n_cmp++;
        if ({s_vld, s_a, s_b, s_s} !== {1'b1, prev}) begin
          n_err++; $display("FAIL rnd_hold cyc%0d: got %h want %h", cyc, {s_vld, s_a, s_b, s_s}, {1'b1, prev});
        end
      end
      prev_stall = s_vld && !ordy;
      prev = {s_a, s_b, s_s};
      if (did_out) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd_unexpected_word cyc%0d: got %h want none", cyc, s_b);
        end else begin
          e = q.pop_front();
          if ({s_a, s_b, s_s} !== e) begin
            n_err++; $display("FAIL rnd_word%0d: got %h/%h/%b want %h/%h/%b", nout, s_a, s_b, s_s, e.a, e.b, e.s);
          end
        end
        nout++;
      end
      if (did_acc) begin
        q.push_back(model(a, b, w));
        nacc++;
      end
    end
    n_cmp++; if (nacc !== 10000) begin n_err++; $display("FAIL rnd_accepted: got %0d want 10000", nacc); end
    n_cmp++; if (q.size() !== 0) begin n_err++; $display("FAIL rnd_drain: got %0d pending want 0", q.size()); end
    $display("random: %0d words accepted, %0d delivered in %0d cycles", nacc, nout, cyc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
